// File: rtl/vector_recorder.sv
`default_nettype none
// ============================================================================
// Module   : vector_recorder
// Purpose  : Records up to DEPTH words of `vec` on `sample` strobes during a
//            capture session, then drains them in capture order over a
//            valid/ready read port. Optional 32-bit MISR signature over every
//            captured word.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            start, stop       - arm a new session / end capture and drain
//            sample, vec       - capture strobe and word to record
//            rd_valid, rd_data, rd_ready - drain handshake
//            state             - 00 IDLE, 01 CAPTURE, 10 DRAIN
//            count             - words captured in the current session
//            overflow          - sticky, a sample was lost to a full buffer
//            done              - one-cycle pulse when the drain completes
//            signature         - MISR value (0 unless VEC_RECORDER_MISR_EN)
// Config   : define VEC_RECORDER_MISR_EN to build the signature register.
// Revision : 1.0 - initial release
// ============================================================================
module vector_recorder #(
   parameter int W     = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          sample,
   input  logic [W-1:0]  vec,
   output logic          rd_valid,
   output logic [W-1:0]  rd_data,
   input  logic          rd_ready,
   output logic [1:0]    state,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          done,
   output logic [31:0]   signature
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_CAPTURE = 2'b01,
      ST_DRAIN   = 2'b10
   } state_t;

   localparam logic [AW:0] c_full = (AW+1)'(DEPTH);
   localparam logic [AW:0] c_last = (AW+1)'(DEPTH - 1);

   state_t          state_q, state_d;
   logic [AW:0]     count_q, count_d;     // also serves as the write pointer
   logic [AW:0]     rd_ptr_q, rd_ptr_d;   // next word to move into rd_data
   logic            rd_valid_q, rd_valid_d;
   logic [W-1:0]    rd_data_q, rd_data_d;
   logic            overflow_q, overflow_d;
   logic            done_q, done_d;
   logic            wr_en;

   logic [W-1:0]    buf_mem [DEPTH];

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      wr_en      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_CAPTURE;
               count_d    = '0;
               rd_ptr_d   = '0;
               overflow_d = 1'b0;
            end
         end

         ST_CAPTURE: begin
            if (sample) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
            end
            // The sample that fills the last slot ends capture on its own.
            if (stop || (sample && (count_q == c_last))) begin
               state_d = ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (sample && (count_q == c_full)) begin
               overflow_d = 1'b1;
            end
            if (start) begin
               // Abort the drain and re-arm; start's clears win over overflow.
               state_d    = ST_CAPTURE;
               count_d    = '0;
               rd_ptr_d   = '0;
               overflow_d = 1'b0;
               rd_valid_d = 1'b0;
            end else if (!rd_valid_q || rd_ready) begin
               // Output register is empty or being emptied this cycle.
               if (rd_ptr_q != count_q) begin
                  rd_data_d  = buf_mem[rd_ptr_q[AW-1:0]];
                  rd_valid_d = 1'b1;
                  rd_ptr_d   = rd_ptr_q + 1'b1;
               end else begin
                  rd_valid_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   // Buffer storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         buf_mem[count_q[AW-1:0]] <= vec;
      end
   end

`ifdef VEC_RECORDER_MISR_EN
   logic [31:0] sig_q, sig_d;
   logic [31:0] vec_ext;
   logic        sig_clear;

   // start is only honoured outside CAPTURE, and always clears the MISR.
   assign sig_clear = start && (state_q != ST_CAPTURE);

   always_comb begin
      vec_ext        = '0;
      vec_ext[W-1:0] = vec;
      sig_d          = sig_q;
      if (sig_clear) begin
         sig_d = '0;
      end else if (wr_en) begin
         sig_d = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ vec_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

   assign state    = state_q;
   assign count    = count_q;
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign overflow = overflow_q;
   assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_recorder
// Purpose  : Directed self-checking bench for vector_recorder (W=32, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_recorder;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic          stop;
   logic          sample;
   logic [W-1:0]  vec;
   logic          rd_valid;
   logic [W-1:0]  rd_data;
   logic          rd_ready;
   logic [1:0]    state;
   logic [AW:0]   count;
   logic          overflow;
   logic          done;
   logic [31:0]   signature;

   int n_checks;
   int n_fail;

   logic [31:0] sig_exp1;
   logic [31:0] sig_exp2;

   vector_recorder #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .sample    (sample),
      .vec       (vec),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_ready  (rd_ready),
      .state     (state),
      .count     (count),
      .overflow  (overflow),
      .done      (done),
      .signature (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle so outputs show post-edge values.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
`ifdef VEC_RECORDER_MISR_EN
      sig_exp1 = 32'h0000_0001;
      sig_exp2 = 32'h0000_0003;
`else
      sig_exp1 = 32'h0;
      sig_exp2 = 32'h0;
`endif
      reset = 1'b1; start = 1'b0; stop = 1'b0; sample = 1'b0;
      vec = '0; rd_ready = 1'b0;
      tick; tick;
      reset = 1'b0;

      // Reset state
      check_eq("rst_state",    32'(state),     32'd0);
      check_eq("rst_rd_valid", 32'(rd_valid),  32'd0);
      check_eq("rst_count",    32'(count),     32'd0);
      check_eq("rst_overflow", 32'(overflow),  32'd0);
      check_eq("rst_done",     32'(done),      32'd0);
      check_eq("rst_sig",      signature,      32'd0);
      check_eq("rst_rd_data",  rd_data,        32'd0);

      // Basic capture of three words, drain with rd_ready held high
      rd_ready = 1'b1;
      start = 1'b1; tick; start = 1'b0;
      check_eq("b_state_cap", 32'(state), 32'd1);
      check_eq("b_count0",    32'(count), 32'd0);
      sample = 1'b1; vec = 32'hA5A5_A5A5; tick;
      check_eq("b_count1", 32'(count), 32'd1);
      vec = 32'h0000_FFFF; tick;
      vec = 32'h1234_5678; tick;
      sample = 1'b0;
      check_eq("b_count3", 32'(count), 32'd3);
      stop = 1'b1; tick; stop = 1'b0;
      check_eq("b_state_drain", 32'(state),    32'd2);
      check_eq("b_valid_n1",    32'(rd_valid), 32'd0);
      tick;
      check_eq("b_valid_w0", 32'(rd_valid), 32'd1);
      check_eq("b_data_w0",  rd_data,       32'hA5A5_A5A5);
      tick;
      check_eq("b_data_w1",  rd_data,       32'h0000_FFFF);
      tick;
      check_eq("b_valid_w2", 32'(rd_valid), 32'd1);
      check_eq("b_data_w2",  rd_data,       32'h1234_5678);
      tick;
      check_eq("b_valid_end", 32'(rd_valid), 32'd0);
      check_eq("b_done",      32'(done),     32'd1);
      check_eq("b_state_end", 32'(state),    32'd0);
      check_eq("b_count_end", 32'(count),    32'd3);
      tick;
      check_eq("b_done_pulse", 32'(done), 32'd0);

      // Fill to DEPTH, auto drain, overflow, stall mid-drain
      rd_ready = 1'b0;
      start = 1'b1; tick; start = 1'b0;
      sample = 1'b1;
      vec = 32'h11; tick;
      vec = 32'h22; tick;
      vec = 32'h33; tick;
      check_eq("f_state_cap3", 32'(state), 32'd1);
      vec = 32'h44; tick;
      check_eq("f_count4",     32'(count), 32'd4);
      check_eq("f_auto_drain", 32'(state), 32'd2);
      check_eq("f_ovf_before", 32'(overflow), 32'd0);
      vec = 32'h55; tick;
      sample = 1'b0;
      check_eq("f_overflow", 32'(overflow), 32'd1);
      check_eq("f_count_hold", 32'(count), 32'd4);
      check_eq("f_data_w0",  rd_data, 32'h11);
      rd_ready = 1'b1; tick; rd_ready = 1'b0;
      check_eq("f_data_w1", rd_data, 32'h22);
      for (int i = 0; i < 3; i++) begin
         tick;
         check_eq("f_stall_valid", 32'(rd_valid), 32'd1);
         check_eq("f_stall_data",  rd_data,       32'h22);
      end
      rd_ready = 1'b1; tick;
      check_eq("f_data_w2", rd_data, 32'h33);
      tick;
      check_eq("f_data_w3", rd_data, 32'h44);
      tick;
      check_eq("f_valid_end", 32'(rd_valid), 32'd0);
      check_eq("f_done",      32'(done),     32'd1);
      check_eq("f_state_end", 32'(state),    32'd0);
      check_eq("f_ovf_sticky", 32'(overflow), 32'd1);

      // Sample ignored in IDLE
      sample = 1'b1; vec = 32'h66; tick; sample = 1'b0;
      check_eq("i_count_idle", 32'(count), 32'd4);
      check_eq("i_state_idle", 32'(state), 32'd0);

      // Reset has priority over a simultaneous start
      reset = 1'b1; start = 1'b1; tick; reset = 1'b0; start = 1'b0;
      check_eq("p_state",    32'(state),    32'd0);
      check_eq("p_overflow", 32'(overflow), 32'd0);
      check_eq("p_count",    32'(count),    32'd0);

      // Empty session: start then immediate stop
      start = 1'b1; tick; start = 1'b0;
      stop = 1'b1; tick; stop = 1'b0;
      check_eq("e_state_drain", 32'(state),    32'd2);
      check_eq("e_valid_n1",    32'(rd_valid), 32'd0);
      check_eq("e_done_n1",     32'(done),     32'd0);
      tick;
      check_eq("e_done",   32'(done),     32'd1);
      check_eq("e_state",  32'(state),    32'd0);
      check_eq("e_valid",  32'(rd_valid), 32'd0);
      tick;
      check_eq("e_done_pulse", 32'(done), 32'd0);

      // Reset during drain after one transfer
      start = 1'b1; tick; start = 1'b0;
      sample = 1'b1; vec = 32'hAA; tick;
      vec = 32'hBB; tick; sample = 1'b0;
      stop = 1'b1; tick; stop = 1'b0;
      tick;
      check_eq("r_data_w0", rd_data, 32'hAA);
      tick;
      check_eq("r_data_w1", rd_data, 32'hBB);
      reset = 1'b1; tick; reset = 1'b0; rd_ready = 1'b0;
      check_eq("r_state",    32'(state),    32'd0);
      check_eq("r_valid",    32'(rd_valid), 32'd0);
      check_eq("r_count",    32'(count),    32'd0);
      check_eq("r_overflow", 32'(overflow), 32'd0);
      check_eq("r_rd_data",  rd_data,       32'd0);

      // Signature, then start aborting a drain
      start = 1'b1; tick; start = 1'b0;
      sample = 1'b1; vec = 32'h0000_0001; tick;
      check_eq("s_sig1", signature, sig_exp1);
      vec = 32'h0000_0000; tick; sample = 1'b0;
      check_eq("s_sig2", signature, sig_exp2);
      stop = 1'b1; tick; stop = 1'b0;
      tick;
      check_eq("a_valid_before", 32'(rd_valid), 32'd1);
      check_eq("a_data_before",  rd_data,       32'h1);
      start = 1'b1; tick; start = 1'b0;
      check_eq("a_valid_after", 32'(rd_valid), 32'd0);
      check_eq("a_state_cap",   32'(state),    32'd1);
      check_eq("a_count_clr",   32'(count),    32'd0);
      check_eq("a_sig_clr",     signature,     32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vector_recorder.md
VECTOR_RECORDER -- requirements
Module: vector_recorder

Interface
REQ-001 Parameter W, default 32, width of one captured vector word, legal range 1..32.
REQ-002 Parameter DEPTH, default 256, buffer capacity in words, power of two, minimum 2.
REQ-003 Parameter AW, default $clog2(DEPTH), buffer address width.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  arms a new capture session.
REQ-007 Port stop  input  1  ends capture and begins drain.
REQ-008 Port sample  input  1  capture strobe for vec.
REQ-009 Port vec  input  W  vector word to record.
REQ-010 Port rd_valid  output  1  rd_data holds a valid buffered word.
REQ-011 Port rd_data  output  W  oldest undrained word.
REQ-012 Port rd_ready  input  1  consumer accepts rd_data.
REQ-013 Port state  output  2  00 IDLE, 01 CAPTURE, 10 DRAIN; 11 is never driven.
REQ-014 Port count  output  AW+1  words captured in the current session.
REQ-015 Port overflow  output  1  sticky; a sample was lost because the buffer was full.
REQ-016 Port done  output  1  one-cycle pulse when the drain completes.
REQ-017 Port signature  output  32  MISR over captured words (see Configuration).

Function
REQ-018 IDLE, start=1: next cycle state=CAPTURE; count, write pointer, read pointer, overflow and signature cleared.
REQ-019 CAPTURE, sample=1: vec written at write pointer; count increments by 1 the next cycle.
REQ-020 CAPTURE, stop=1: state=DRAIN next cycle; a simultaneous sample is still captured.
REQ-021 CAPTURE, the sample that makes count equal DEPTH: state=DRAIN next cycle, no stop required.
REQ-022 sample is ignored in IDLE and DRAIN; in DRAIN with count==DEPTH, sample=1 sets overflow, held until the next start or reset.
REQ-023 start is ignored in CAPTURE; in DRAIN it aborts the drain, rd_valid deasserts next cycle, then REQ-018 applies.
REQ-024 stop is ignored outside CAPTURE.
REQ-025 Stop or full sampled at edge N: state=DRAIN from N+1; rd_valid=1 from N+2 when count>0.
REQ-026 Transfer occurs on a cycle with rd_valid and rd_ready both high; words leave in capture order.
REQ-027 With rd_valid=1 and rd_ready=0, rd_data and rd_valid hold unchanged.
REQ-028 With rd_ready held high, one word transfers per cycle with no bubbles.
REQ-029 After the final transfer, next cycle: rd_valid=0, done=1 for exactly one cycle, state=IDLE; count retains its value until the next start.
REQ-030 DRAIN entered with count==0: done=1 and state=IDLE at N+2; rd_valid is never asserted.

Reset
REQ-031 reset=1 has priority over every other input in any state and mid-transfer.
REQ-032 Reset values: state=IDLE, rd_valid=0, count=0, overflow=0, done=0, signature=0, pointers=0; rd_data=0.
REQ-033 Buffer contents are not cleared by reset.

Configuration
REQ-034 Macro VEC_RECORDER_MISR_EN compiles in the signature register.
REQ-035 With VEC_RECORDER_MISR_EN: on each captured word, signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} XOR zero-extended vec.
REQ-036 Without VEC_RECORDER_MISR_EN: signature is driven constant 0 and no MISR logic exists.

Verification
REQ-037 start; sample A5A5A5A5, 0000FFFF, 12345678; stop; rd_ready=1 -> rd_data A5A5A5A5, 0000FFFF, 12345678 on consecutive cycles, count=3, done one pulse, state IDLE.
REQ-038 DEPTH=4: four samples -> auto DRAIN, no stop needed; fifth sample -> overflow=1; four words drain in order.
REQ-039 rd_ready low 3 cycles mid-drain -> rd_data and rd_valid stable all 3 cycles; no word lost or duplicated.
REQ-040 start then immediate stop, zero samples -> done=1 two cycles after stop, rd_valid stays 0.
REQ-041 reset asserted in DRAIN after one transfer -> next cycle state=IDLE, rd_valid=0, count=0, overflow=0.
REQ-042 MISR_EN defined: capture 00000001 then 00000000 -> signature 00000001 then 00000003; macro undefined -> signature stays 0.
